fpnew_opgroup_result_buffer: RTL and testbench
==============================================

# fpnew_opgroup_result_buffer

Elastic result buffer placed directly downstream of an operation-group block. It accepts result/status/extension-bit/tag beats on a valid/ready handshake, stores up to `Depth` of them in order, and presents them on a registered output handshake to the FPU output arbiter. It also keeps a sticky floating-point exception flag register built from every result it delivers. It decouples opgroup-slice back-pressure from the top-level `out_ready_i`.

## Interface
- `Width`, 32, result data width in bits.
- `Depth`, 2, number of buffer entries. Legal values are 1..16; non-power-of-two values are supported.
- `TagType`, logic, type of the opaque tag carried alongside each result.
- `CNT_W` (localparam), `$clog2(Depth+1)`, width of the occupancy counter.

Ports:
- `clk_i`  in  1  clock; rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous flush; discards all buffered entries.
- `in_result_i`  in  Width  result from the opgroup.
- `in_status_i`  in  fpnew_pkg::status_t (5)  exception flags of the result: NV, DZ, OF, UF, NX.
- `in_ext_bit_i`  in  1  extension bit of the result.
- `in_tag_i`  in  TagType  tag of the result.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  buffer can accept a beat.
- `out_result_o`  out  Width  head entry result.
- `out_status_o`  out  status_t  head entry status.
- `out_ext_bit_o`  out  1  head entry extension bit.
- `out_tag_o`  out  TagType  head entry tag.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  consumer accepts the head entry.
- `fflags_o`  out  status_t  sticky OR of the status of every popped entry.
- `fflags_clr_i`  in  1  clears `fflags_o`.
- `count_o`  out  CNT_W  current occupancy.
- `busy_o`  out  1  buffer holds at least one entry.

## Operation
- Storage is a circular array of `Depth` entries, each holding {result, status, ext_bit, tag}.
  - Write pointer and read pointer each wrap from `Depth-1` to 0.
  - An occupancy counter runs from 0 to `Depth`.
- Push occurs when `in_valid_i && in_ready_o && !flush_i`. The beat is written at the write pointer and the write pointer advances.
- Pop occurs when `out_valid_o && out_ready_i && !flush_i`. The read pointer advances.
- Counter update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop happen in the same cycle.
- `in_ready_o = (count != Depth)`. It is a pure function of state, with no combinational path from `out_ready_i`.
  - When the buffer is full, a same-cycle pop does not open the input.
- Output side:
  - `out_valid_o = (count != 0)`.
  - `out_*_o` are driven from the entry at the read pointer.
  - When `out_valid_o` is 0, the `out_*_o` data outputs are don't-care.
- Output stability: while `out_valid_o && !out_ready_i`, all `out_*_o` hold their values. Only `flush_i` may withdraw a valid entry.
- `fflags_o` next-state:
  - `fflags_clr_i` clears first.
  - The status of the popped entry is then ORed in.
  - So clear and pop in the same cycle gives `fflags_o = popped status`.
  - `flush_i` does not affect `fflags_o`. Discarded entries never contribute to it.
- Flush:
  - Pointers and counter return to 0 on the next edge.
  - A push or pop in the flush cycle is ignored.
  - `in_ready_o` is 1 in the following cycle.
- `busy_o = (count != 0)`. `count_o` is the occupancy counter.
- `in_valid_i` while `in_ready_o` = 0 is legal. The upstream holds the beat until it is accepted.

## Timing
- Reset values:
  - Pointers 0, count 0.
  - `out_valid_o` = 0, `in_ready_o` = 1, `busy_o` = 0, `count_o` = 0, `fflags_o` = 5'b0.
  - Entry storage is not reset.
- Latency: a beat pushed at edge N appears with `out_valid_o` = 1 after edge N. Minimum 1 cycle; there is no fall-through.
- Throughput: one push and one pop per cycle in steady state when 0 < count < Depth.
  - For `Depth` = 1 the maximum rate is one beat every 2 cycles.
- Reset asserted mid-operation discards all entries immediately (asynchronously) and forces the reset values above.
- A full buffer with the consumer stalled holds indefinitely: `in_ready_o` stays 0 and data is neither lost nor reordered.

## Test plan
- Fill and order, `Depth`=2, `out_ready_i`=0:
  - Push A (result 0x3F800000, tag 1), then B (0x40000000, tag 2) → after 2 edges `count_o`=2, `in_ready_o`=0.
  - Raise `out_ready_i` → A then B appear on consecutive cycles, then `out_valid_o`=0.
- Streaming, `Depth`=4:
  - Continuous valid input with `out_ready_i`=1 → `count_o` stays 1 and one beat per cycle exits in order, tags 0..15 with no gaps or duplicates.
- Back-pressure stability: `out_ready_i`=0 for 5 cycles with head C valid → `out_*_o` are unchanged in every cycle; C is popped when `out_ready_i`=1.
- Sticky flags:
  - Pop entries with status 5'b00001, then 5'b10000 → `fflags_o`=5'b10001.
  - Assert `fflags_clr_i` together with a pop of status 5'b00100 → `fflags_o`=5'b00100.
- Flush: with count 3 and a push presented in the same cycle, assert `flush_i` → next cycle `count_o`=0, `out_valid_o`=0, `in_ready_o`=1, `fflags_o` unchanged.
- Async reset: drop `rst_ni` mid-cycle with count 2 → `out_valid_o`=0 and `count_o`=0 without a clock edge. After release, a new push reaches the output after 1 edge.

Source files
------------

// File: rtl/fpnew_opgroup_result_buffer.sv
// Elastic in-order result buffer between an opgroup block and the FPU output arbiter.
// Keeps a sticky exception-flag register accumulated from every delivered result.
module fpnew_opgroup_result_buffer #(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 2,
  parameter type         TagType = logic,
  localparam int unsigned CNT_W  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [Width-1:0] in_result_i,
  input  logic [4:0]       in_status_i,
  input  logic             in_ext_bit_i,
  input  TagType           in_tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_result_o,
  output logic [4:0]       out_status_o,
  output logic             out_ext_bit_o,
  output TagType           out_tag_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [4:0]       fflags_o,
  input  logic             fflags_clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o
);

  localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] result_mem [Depth];
  logic [4:0]       status_mem [Depth];
  logic             ext_mem    [Depth];
  TagType           tag_mem    [Depth];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [4:0]       fflags_q;
  logic [4:0]       fflags_next;
  logic             push, pop;

  // Ready depends only on occupancy, so a full buffer stays closed even while it pops.
  assign in_ready_o  = (count_q != CNT_W'(Depth));
  assign out_valid_o = (count_q != '0);
  assign busy_o      = out_valid_o;
  assign count_o     = count_q;
  assign fflags_o    = fflags_q;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  assign out_result_o  = result_mem[rd_ptr_q];
  assign out_status_o  = status_mem[rd_ptr_q];
  assign out_ext_bit_o = ext_mem[rd_ptr_q];
  assign out_tag_o     = tag_mem[rd_ptr_q];

  always_comb begin
    fflags_next = fflags_clr_i ? '0 : fflags_q;
    if (pop) fflags_next = fflags_next | out_status_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push)
          wr_ptr_q <= (wr_ptr_q == PTR_W'(Depth - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)
          rd_ptr_q <= (rd_ptr_q == PTR_W'(Depth - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        if (push && !pop)
          count_q <= count_q + CNT_W'(1);
        else if (pop && !push)
          count_q <= count_q - CNT_W'(1);
      end
      fflags_q <= fflags_next;
    end
  end

  // Entry storage carries no reset; validity is tracked solely by the counter.
  always_ff @(posedge clk_i) begin
    if (push) begin
      result_mem[wr_ptr_q] <= in_result_i;
      status_mem[wr_ptr_q] <= in_status_i;
      ext_mem[wr_ptr_q]    <= in_ext_bit_i;
      tag_mem[wr_ptr_q]    <= in_tag_i;
    end
  end

endmodule

// File: tb/tb_fpnew_opgroup_result_buffer.sv
// Directed bench for the opgroup result buffer (Depth 4, 8-bit tags).
module tb_fpnew_opgroup_result_buffer;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_result;
  logic [4:0]  in_status;
  logic        in_ext;
  logic [7:0]  in_tag;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_result;
  logic [4:0]  out_status;
  logic        out_ext;
  logic [7:0]  out_tag;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic [2:0]  count;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpnew_opgroup_result_buffer #(
    .Width  (W),
    .Depth  (D),
    .TagType(logic [7:0])
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_result_i  (in_result),
    .in_status_i  (in_status),
    .in_ext_bit_i (in_ext),
    .in_tag_i     (in_tag),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_result_o (out_result),
    .out_status_o (out_status),
    .out_ext_bit_o(out_ext),
    .out_tag_o    (out_tag),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .fflags_o     (fflags),
    .fflags_clr_i (fflags_clr),
    .count_o      (count),
    .busy_o       (busy)
  );

  task automatic push(input logic [31:0] r, input logic [4:0] s, input logic e, input logic [7:0] t);
    in_result = r; in_status = s; in_ext = e; in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_result = '0; in_status = '0; in_ext = 1'b0;
    in_tag = '0; in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
    #12;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (fflags !== 5'b0) begin fails++; $display("FAIL reset_fflags got %b want 00000", fflags); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_order;
    logic [31:0] exp_r [4];
    exp_r[0] = 32'h3F800000; exp_r[1] = 32'h40000000;
    exp_r[2] = 32'h40400000; exp_r[3] = 32'h40800000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(exp_r[i], 5'b0, i[0], 8'(i + 1));
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d want 4", count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %b want 0", in_ready); end
    // Extra beat held at the input while full must not be taken.
    in_result = 32'hDEADBEEF; in_tag = 8'hEE; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1; in_valid = 1'b0;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_hold_count got %0d want 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_result !== exp_r[i] || out_tag !== 8'(i + 1)) begin
        fails++;
        $display("FAIL drain_%0d got v=%b r=%h t=%0d want v=1 r=%h t=%0d",
                 i, out_valid, out_result, out_tag, exp_r[i], i + 1);
      end
      @(posedge clk); #1;
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b want 0", out_valid); end
    tests++; if (fflags !== 5'b0) begin fails++; $display("FAIL drain_fflags got %b want 00000", fflags); end
  endtask

  task automatic test_streaming;
    int bad = 0;
    out_ready = 1'b1;
    in_status = 5'b0; in_ext = 1'b0;
    in_tag = 8'd0; in_result = 32'h100; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_tag !== 8'(i) || out_result !== 32'h100 + 32'(i) || count !== 3'd1) begin
        bad++;
        $display("FAIL stream_%0d got v=%b t=%0d c=%0d want v=1 t=%0d c=1", i, out_valid, out_tag, count, i);
      end
      if (i < 15) begin in_tag = 8'(i + 1); in_result = 32'h100 + 32'(i + 1); end
      else in_valid = 1'b0;
    end
    tests++; if (bad != 0) fails++;
    @(posedge clk); #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL stream_end_count got %0d want 0", count); end
  endtask

  task automatic test_back_pressure;
    int bad = 0;
    out_ready = 1'b0;
    push(32'hC0DE0001, 5'b00001, 1'b1, 8'h0C);
    push(32'hC0DE0002, 5'b10000, 1'b0, 8'h0E);
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_result !== 32'hC0DE0001 || out_status !== 5'b00001 ||
          out_ext !== 1'b1 || out_tag !== 8'h0C) begin
        bad++;
        $display("FAIL stall_%0d got r=%h s=%b e=%b t=%h want r=c0de0001 s=00001 e=1 t=0c",
                 i, out_result, out_status, out_ext, out_tag);
      end
      @(posedge clk); #1;
    end
    tests++; if (bad != 0) fails++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_tag !== 8'h0E || fflags !== 5'b00001) begin
      fails++; $display("FAIL pop_c got t=%h f=%b want t=0e f=00001", out_tag, fflags);
    end
    @(posedge clk); #1;
    tests++; if (fflags !== 5'b10001) begin fails++; $display("FAIL sticky got %b want 10001", fflags); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL sticky_count got %0d want 0", count); end
  endtask

  task automatic test_clear_with_pop;
    out_ready = 1'b0;
    push(32'h0F0F0F0F, 5'b00100, 1'b0, 8'h0F);
    fflags_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    tests++; if (fflags !== 5'b00100) begin fails++; $display("FAIL clr_pop got %b want 00100", fflags); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'hAAAA0000 + 32'(i), 5'b01000, 1'b0, 8'(i));
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL preflush_count got %0d want 3", count); end
    in_result = 32'hBBBB0000; in_status = 5'b00010; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_state got c=%0d v=%b r=%b want c=0 v=0 r=1", count, out_valid, in_ready);
    end
    tests++; if (fflags !== 5'b00100) begin fails++; $display("FAIL flush_fflags got %b want 00100", fflags); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    push(32'h11111111, 5'b00001, 1'b0, 8'h11);
    push(32'h22222222, 5'b00001, 1'b0, 8'h22);
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL prerst_count got %0d want 2", count); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      fails++; $display("FAIL async_rst got v=%b c=%0d want v=0 c=0", out_valid, count);
    end
    tests++; if (fflags !== 5'b0) begin fails++; $display("FAIL async_rst_fflags got %b want 00000", fflags); end
    @(negedge clk); rst_n = 1'b1;
    push(32'h33333333, 5'b0, 1'b1, 8'h33);
    tests++; if (out_valid !== 1'b1 || out_result !== 32'h33333333 || out_tag !== 8'h33) begin
      fails++; $display("FAIL post_rst_push got v=%b r=%h t=%h want v=1 r=33333333 t=33", out_valid, out_result, out_tag);
    end
  endtask

  initial begin
    test_reset();
    test_fill_order();
    test_streaming();
    test_back_pressure();
    test_clear_with_pop();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
